// File: rtl/inst_fetch.sv
// Instruction fetch unit: reads words from instruction memory into a small prefetch FIFO and delivers them on request.
// INST_FETCH_PREFETCH_EN selects a 2-deep FIFO with speculative reads; otherwise 1-deep and reads only on demand.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Fetch_En,
   input  logic        Redirect,
   input  logic [31:0] Redirect_Addr,
   output logic        Mem_Req,
   output logic [31:0] Mem_Addr,
   input  logic        Mem_Ready,
   input  logic [31:0] Mem_Data,
   output logic        W_Enable,
   output logic [31:0] Data,
   output logic [31:0] PC,
   output logic        Busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DROP = 2'd2;

`ifdef INST_FETCH_PREFETCH_EN
   localparam logic [1:0] DEPTH = 2'd2;
`else
   localparam logic [1:0] DEPTH = 2'd1;
`endif

   logic [1:0]  state, state_nxt;
   logic [31:0] fetch_pc, fetch_pc_nxt;
   logic [31:0] drop_addr;
   logic        pending, pending_nxt;
   logic [1:0]  count, cnt_nxt;
   logic [31:0] fifo_pc   [2];
   logic [31:0] fifo_word [2];
   logic        push, pop, wr_idx, issue_ok;
   logic [31:0] redir_pc;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^Redirect_Addr[1:0];
   assign redir_pc = {Redirect_Addr[31:2], 2'b00};

   always_comb begin
      push = (state == WAIT) && Mem_Ready && !Redirect;
      pop  = (Fetch_En || pending) && (count != 2'd0) && !Redirect;

      if (Redirect)
         cnt_nxt = 2'd0;
      else
         cnt_nxt = count + {1'b0, push} - {1'b0, pop};

      if (Redirect)
         pending_nxt = pending || Fetch_En;
      else if (pop)
         pending_nxt = 1'b0;
      else if (Fetch_En)
         pending_nxt = 1'b1;
      else
         pending_nxt = pending;

      if (Redirect)
         fetch_pc_nxt = redir_pc;
      else if (push)
         fetch_pc_nxt = fetch_pc + 32'd4;
      else
         fetch_pc_nxt = fetch_pc;

      wr_idx = (count == 2'd2) || ((count == 2'd1) && !pop);
   end

   // Issue decision looks at next-cycle occupancy so completions can chain back-to-back
`ifdef INST_FETCH_PREFETCH_EN
   assign issue_ok = (cnt_nxt < DEPTH);
`else
   assign issue_ok = pending_nxt && (cnt_nxt == 2'd0);
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = issue_ok ? WAIT : IDLE;
         WAIT: begin
            if (Mem_Ready)
               state_nxt = issue_ok ? WAIT : IDLE;
            else if (Redirect)
               state_nxt = DROP;
         end
         DROP: begin
            if (Mem_Ready)
               state_nxt = issue_ok ? WAIT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         drop_addr <= RESET_PC;
         pending   <= 1'b0;
         count     <= 2'd0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         pending  <= pending_nxt;
         count    <= cnt_nxt;
         if ((state == WAIT) && !Mem_Ready && Redirect)
            drop_addr <= fetch_pc;
      end
   end

   // Head always lives in entry 0; a pop shifts entry 1 down before any push lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_pc[0]   <= 32'd0;
         fifo_pc[1]   <= 32'd0;
         fifo_word[0] <= 32'd0;
         fifo_word[1] <= 32'd0;
      end else begin
         if (pop) begin
            fifo_pc[0]   <= fifo_pc[1];
            fifo_word[0] <= fifo_word[1];
         end
         if (push) begin
            fifo_pc[wr_idx]   <= fetch_pc;
            fifo_word[wr_idx] <= Mem_Data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         W_Enable <= 1'b0;
         Data     <= 32'd0;
         PC       <= RESET_PC;
      end else begin
         W_Enable <= pop;
         if (pop) begin
            Data <= fifo_word[0];
            PC   <= fifo_pc[0];
         end
      end
   end

   assign Mem_Req  = (state != IDLE);
   assign Mem_Addr = (state == DROP) ? drop_addr : fetch_pc;
   assign Busy     = pending;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the multi-cycle MIPS32 core: the producer side of the instruction-register load interface. It issues word reads to instruction memory over a request/ready handshake and buffers returned words in a small prefetch queue. Each word is delivered as a one-cycle `W_Enable` pulse with `Data` (and its `PC`) when the control FSM asks for the next instruction. A redirect input (branch/jump/exception target) flushes the queue and restarts fetching.

## Interface
- `RESET_PC`, default `32'h0000_3000`: fetch address after reset; must be word-aligned.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Fetch_En`  in  1  one-cycle request from control FSM (IF state) for the next instruction.
- `Redirect`  in  1  one-cycle pulse: restart fetch at `Redirect_Addr`.
- `Redirect_Addr`  in  32  new fetch target; bits [1:0] ignored, forced to 00.
- `Mem_Req`  out  1  read request to instruction memory.
- `Mem_Addr`  out  32  word address of the request; bits [1:0] always 00.
- `Mem_Ready`  in  1  memory accepts and completes the request this cycle.
- `Mem_Data`  in  32  read data, valid when `Mem_Req && Mem_Ready`.
- `W_Enable`  out  1  one-cycle pulse: `Data` holds a new instruction.
- `Data`  out  32  instruction word; holds its value between pulses.
- `PC`  out  32  address of the word on `Data`; holds between pulses.
- `Busy`  out  1  a `Fetch_En` is pending and not yet served.

## Operation
- Registers: `Fetch_PC` (next address to request), 2-entry FIFO of {pc, word}, `pending` flag, FSM state.
- FSM states:
  - `IDLE`: no outstanding request.
  - `WAIT`: `Mem_Req` high.
  - `DROP`: request outstanding but its response is to be discarded.
- `IDLE` → `WAIT` when occupancy + outstanding < depth: drive `Mem_Req=1`, `Mem_Addr=Fetch_PC`.
- `WAIT` rules:
  - `Mem_Req`/`Mem_Addr` are held stable until `Mem_Ready`.
  - On `Mem_Ready`: push {Fetch_PC, Mem_Data}; `Fetch_PC += 4` (wraps modulo 2^32); back to `IDLE`, or stay in `WAIT` with the new address if space remains.
- At most one outstanding request.
- Pop condition: `(Fetch_En || pending) && !empty`.
  - Pop loads `Data`, `PC` from head; asserts `W_Enable` for exactly one cycle; clears `pending`.
  - `Fetch_En` with empty FIFO sets `pending`.
  - `Fetch_En` while `pending` is already set is absorbed; no counting.
- `Redirect` behaviour:
  - FIFO flushed; `Fetch_PC <= {Redirect_Addr[31:2],2'b00}`; `pending` preserved.
  - In `WAIT` without `Mem_Ready`: go to `DROP`; keep old address until `Mem_Ready`; discard that data; then request the new target.
  - `Redirect` and `Mem_Ready` in the same cycle: data discarded; next request is the target.
  - `Redirect` and pop in the same cycle: redirect wins; no `W_Enable`; `pending` set if `Fetch_En` was high.
- Push and pop in the same cycle on a full FIFO is legal; occupancy is unchanged.
- Reset values:
  - `Mem_Req=0`, `Mem_Addr=RESET_PC`, `W_Enable=0`, `Data=0`, `PC=RESET_PC`, `Busy=0`.
  - FIFO empty, FSM in `IDLE`, `Fetch_PC=RESET_PC`.
- Reset mid-transfer abandons the request immediately; memory must tolerate `Mem_Req` dropping.

## Timing
- First request: `Mem_Req` rises in the first cycle after `rst_n` deasserts.
- Buffered hit: `Fetch_En` sampled at edge N → `W_Enable=1` in cycle N..N+1.
- Empty FIFO: word pushed at edge M → pop at edge M+1 → `W_Enable` in the following cycle.
- Back-to-back memory reads sustain one word per cycle when `Mem_Ready` is held high and space exists.
- `Busy` is registered and equals `pending`.

## Configuration
- `INST_FETCH_PREFETCH_EN` defined:
  - FIFO depth 2.
  - Requests issued speculatively whenever space exists.
- Undefined:
  - FIFO depth 1.
  - A request is issued only while `pending` is set and the FIFO is empty; no speculative reads.
  - All handshake, redirect and reset rules are unchanged.

## Test plan
- Reset release, `Mem_Ready` tied 1, prefetch on → `Mem_Addr` `0x3000`, `0x3004`; `Mem_Req` drops with 2 entries; `Fetch_En` → next-cycle `W_Enable`, `PC=0x3000`.
- `Mem_Ready` delayed 3 cycles with `Fetch_En` pending → `Mem_Addr` stable for 4 cycles; `Busy=1` until `W_Enable`; `Data` equals `Mem_Data`.
- `Redirect` to `0x4003` while a request waits → old response dropped; next `Mem_Addr=0x4000`; first `W_Enable` carries `PC=0x4000`.
- `Redirect`, `Mem_Ready` and `Fetch_En` in the same cycle → no `W_Enable`; `pending` set; next delivered `PC` equals the target.
- `Fetch_PC=0xFFFF_FFFC` with a read completing → next `Mem_Addr=0x0000_0000`.
- `rst_n` low mid-`WAIT`, macro undefined → all outputs at reset values; after release no `Mem_Req` until `Fetch_En`.
